// File: rtl/bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_logic_pipe
// Brief    : Registered WIDTH-bit bitwise logic unit with valid/ready handshake,
//            accumulate feedback, equality flag and saturating match counter.
// Revision : 1.0
// ============================================================================
module bitwise_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             eq,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eq_q, eq_d;
    logic             vld_q, vld_d;

    logic             accept;
    logic             match;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;

    assign in_ready = !rst && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign match    = &(a ~^ b);
    assign opb      = acc_en ? acc_q : b;

    always_comb begin
        case (op)
            OP_AND:  res = a & opb;
            OP_OR:   res = a | opb;
            OP_XOR:  res = a ^ opb;
            OP_XNOR: res = a ~^ opb;
            OP_NAND: res = ~(a & opb);
            OP_NOR:  res = ~(a | opb);
            OP_NOTA: res = ~a;
            default: res = a;
        endcase
    end

    always_comb begin
        y_d   = y_q;
        eq_d  = eq_q;
        vld_d = vld_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept) begin
            y_d   = res;
            eq_d  = match;
            vld_d = 1'b1;
            acc_d = res;
            if (match && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
        // clr wins over the accepted beat for acc/counter only; y/eq/valid still load
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            eq_q  <= 1'b0;
            vld_q <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            eq_q  <= eq_d;
            vld_q <= vld_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign y         = y_q;
    assign eq        = eq_q;
    assign out_valid = vld_q;
    assign match_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_logic_pipe
// Brief    : Scoreboard bench for bitwise_logic_pipe (CNT_W=16 and CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_bitwise_logic_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       acc_en = 1'b0;
    logic       out_ready = 1'b1;

    logic        in_ready, out_valid, eq;
    logic [7:0]  y;
    logic [15:0] match_cnt;
    logic        in_ready2, out_valid2, eq2;
    logic [7:0]  y2;
    logic [1:0]  match_cnt2;

    int errors = 0;
    int checks = 0;

    logic [8:0] sb_q[$];
    logic [7:0] acc_m;

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .eq(eq), .match_cnt(match_cnt)
    );

    bitwise_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .out_valid(out_valid2),
        .out_ready(out_ready), .y(y2), .eq(eq2), .match_cnt(match_cnt2)
    );

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    ref_op = x & z;
            3'd1:    ref_op = x | z;
            3'd2:    ref_op = x ^ z;
            3'd3:    ref_op = ~(x ^ z);
            3'd4:    ref_op = ~(x & z);
            3'd5:    ref_op = ~(x | z);
            3'd6:    ref_op = ~x;
            default: ref_op = x;
        endcase
    endfunction

    // Handshakes resolve on the pre-edge values: pop the leaving result, then push the new one.
    always @(posedge clk) begin
        logic [8:0] exp_v;
        logic [7:0] r;
        if (rst) begin
            sb_q.delete();
            acc_m = '0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: output y=%h with no expected entry", y);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({y, eq} !== exp_v) begin
                        errors++;
                        $display("FAIL sb_result: y=%h eq=%b, expected y=%h eq=%b",
                                 y, eq, exp_v[8:1], exp_v[0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                r = ref_op(op, a, acc_en ? acc_m : b);
                sb_q.push_back({r, (a == b)});
                acc_m = r;
            end
            if (clr) acc_m = '0;
        end
    end

    task automatic set_beat(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                            input logic tacc);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        op       = top;
        acc_en   = tacc;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, y, eq, match_cnt} !== 27'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b y=%h eq=%b cnt=%0d, expected all 0",
                     in_ready, out_valid, y, eq, match_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_y [8] = '{8'h24, 8'hBD, 8'h99, 8'h66, 8'hDB, 8'h42, 8'h5A, 8'hA5};
        for (int i = 0; i < 8; i++) begin
            set_beat(8'hA5, 8'h3C, 3'(i), 1'b0);
            @(negedge clk);
            checks++;
            if (y !== exp_y[i] || out_valid !== 1'b1 || eq !== 1'b0 || match_cnt !== 16'd0) begin
                errors++;
                $display("FAIL op_sweep[%0d]: y=%h vld=%b eq=%b cnt=%0d, expected y=%h vld=1 eq=0 cnt=0",
                         i, y, out_valid, eq, match_cnt, exp_y[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drain: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_beat(8'h0F, 8'hF0, 3'd1, 1'b0);
        @(negedge clk);
        set_beat(8'hFF, 8'h0F, 3'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (y !== 8'hFF || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: y=%h vld=%b rdy=%b, expected y=ff vld=1 rdy=0", y, out_valid, in_ready);
        end
        op = 3'd0;
        @(negedge clk);
        op = 3'd2;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b, expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (y !== 8'hF0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_beat2: y=%h vld=%b, expected y=f0 vld=1", y, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_match_counter();
        logic       exp_eq   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] bv       [6] = '{8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A};
        int         exp_cnt  [6] = '{1, 2, 3, 3, 4, 5};
        int         exp_cnt2 [6] = '{1, 2, 3, 3, 3, 3};
        pulse_clr();
        for (int i = 0; i < 6; i++) begin
            set_beat(8'h5A, bv[i], 3'd0, 1'b0);
            @(negedge clk);
            checks++;
            if (eq !== exp_eq[i] || match_cnt !== 16'(exp_cnt[i]) || match_cnt2 !== 2'(exp_cnt2[i])) begin
                errors++;
                $display("FAIL match[%0d]: eq=%b cnt=%0d cnt2=%0d, expected eq=%b cnt=%0d cnt2=%0d",
                         i, eq, match_cnt, match_cnt2, exp_eq[i], exp_cnt[i], exp_cnt2[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (match_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL match_sat_hold: cnt2=%0d, expected 3", match_cnt2);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] av    [3] = '{8'h01, 8'h02, 8'h04};
        logic [7:0] exp_y [3] = '{8'h01, 8'h03, 8'h07};
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            set_beat(av[i], 8'hFF, 3'd2, 1'b1);
            @(negedge clk);
            checks++;
            if (y !== exp_y[i]) begin
                errors++;
                $display("FAIL acc_xor[%0d]: y=%h, expected %h", i, y, exp_y[i]);
            end
        end
        // OR with a=0 in accumulate mode exposes the accumulator on y
        set_beat(8'h00, 8'hFF, 3'd1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (y !== 8'h07) begin
            errors++;
            $display("FAIL acc_value: acc=%h, expected 07", y);
        end
    endtask

    task automatic test_clr_with_beat();
        pulse_clr();
        set_beat(8'h11, 8'h11, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (match_cnt !== 16'd2) begin
            errors++;
            $display("FAIL clr_pre_cnt: cnt=%0d, expected 2", match_cnt);
        end
        set_beat(8'h11, 8'h11, 3'd1, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (match_cnt !== 16'd0 || y !== 8'h11 || out_valid !== 1'b1 || eq !== 1'b1) begin
            errors++;
            $display("FAIL clr_beat: cnt=%0d y=%h vld=%b eq=%b, expected cnt=0 y=11 vld=1 eq=1",
                     match_cnt, y, out_valid, eq);
        end
        set_beat(8'h00, 8'h22, 3'd1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (y !== 8'h00 || match_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clr_acc: acc=%h cnt=%0d, expected acc=00 cnt=0", y, match_cnt);
        end
    endtask

    task automatic test_reset_mid();
        pulse_clr();
        set_beat(8'h33, 8'h33, 3'd0, 1'b0);
        repeat (5) @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (match_cnt !== 16'd5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: cnt=%0d vld=%b, expected cnt=5 vld=1", match_cnt, out_valid);
        end
        set_beat(8'h44, 8'h44, 3'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || match_cnt !== 16'd5 || y !== 8'h33) begin
            errors++;
            $display("FAIL stall_freeze: rdy=%b cnt=%0d y=%h, expected rdy=0 cnt=5 y=33",
                     in_ready, match_cnt, y);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, y, eq, match_cnt} !== 27'd0) begin
            errors++;
            $display("FAIL rstmid_state: rdy=%b vld=%b y=%h eq=%b cnt=%0d, expected all 0",
                     in_ready, out_valid, y, eq, match_cnt);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_release: in_ready=%b, expected 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_backpressure();
        test_match_counter();
        test_accumulate();
        test_clr_with_beat();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results never produced, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, registered successor to the single-bit two-input gate cells: a WIDTH-bit bitwise logic unit with eight selectable operations, one output register stage, and a valid/ready handshake on both sides. It adds three features the combinational cells lack: an accumulate mode that feeds the previous result back as operand B, a registered equality flag (reduction-AND of the XNOR), and a saturating counter of equal-operand beats. It sits between a stimulus/operand source and any downstream consumer that applies backpressure.

## Interface
- WIDTH, 8: operand and result width, ≥1
- CNT_W, 16: match counter width, ≥1
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear of the accumulator and match_cnt; does not affect the output register
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; ignored when acc_en=1
- op  in  3  operation select, sampled with the beat
- acc_en  in  1  accumulate mode, sampled with the beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- y  out  WIDTH  registered result
- eq  out  1  registered flag: a == b for the beat currently in y (raw b)
- match_cnt  out  CNT_W  count of accepted beats with a == b

## Operation
- op encoding: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT A (~a), 111 PASS A.
- Effective operand B is b when acc_en=0 and the internal accumulator acc when acc_en=1.
- Result r = op(a, effective B), computed bitwise across WIDTH bits.
- Accept occurs when in_valid && in_ready.
- On accept: y <= r; eq <= &(a ~^ b), always using the raw b; out_valid <= 1; acc <= r, whether or not acc_en is set.
- match_cnt increments by 1 on every accept where a == b. It saturates at 2^CNT_W-1 and never wraps.
- clr sets acc and match_cnt to 0.
  - clr has priority over an accept in the same cycle: acc=0 and match_cnt=0 afterwards, and that beat is not counted.
  - The beat itself still loads y, eq and out_valid normally. It uses the pre-clear acc if acc_en=1.
- Output register behaviour:
  - If out_valid && out_ready and there is no accept, out_valid <= 0 next cycle.
  - If out_valid && !out_ready, y, eq and out_valid hold unchanged.
- in_ready = !rst && (!out_valid || out_ready). This is combinational and allows a back-to-back beat every cycle while out_ready=1.

## Timing
- Reset values: out_valid=0, y=0, eq=0, match_cnt=0, acc=0; in_ready=0 while rst=1.
- rst takes priority over clr and over any accept. Asserting rst mid-stream discards a held result.
- Latency is one cycle: a beat accepted at edge N shows its result on y/out_valid after edge N.
- match_cnt reflects an accepted beat after the same edge.
- Throughput is one beat per cycle when out_ready=1.
- Stall: with out_valid=1 and out_ready=0, in_ready=0. No beat is accepted and acc and match_cnt are frozen.
- Simultaneous output drain and accept: the new result replaces the old one and out_valid stays 1.
- op and acc_en are sampled only at accept. Changes to them while stalled have no effect.

## Test plan
- WIDTH=8, a=8'hA5, b=8'h3C, out_ready=1, op swept 0..7, one beat per cycle:
  - y sequence 24, BD, 99, 66, DB, 42, 5A, A5, each one cycle after its accept.
  - eq=0 throughout; match_cnt=0.
- Backpressure: out_ready=0, beat1 a=8'h0F b=8'hF0 op=OR, then beat2 held valid with a=8'hFF:
  - y=8'hFF from beat1 holds, in_ready=0, and beat2 is not accepted.
  - Raise out_ready: beat2 is accepted on that cycle, then y shows beat2's result.
- Match counter:
  - Three beats with a=b=8'h5A, then one with a=8'h5A b=8'h5B: match_cnt=3, eq sequence 1,1,1,0.
  - With CNT_W=2, five matching beats: match_cnt=3, held.
- Accumulate XOR: pulse clr, then op=XOR, acc_en=1, a=01,02,04 (b=8'hFF ignored): y=01,03,07, acc=07.
- clr together with a matching accepted beat (a=b=8'h11, match_cnt=2 beforehand): match_cnt=0 and acc=0 next cycle, while y still updates with out_valid=1.
- Reset mid-operation: rst while out_valid=1 and out_ready=0 with match_cnt=5:
  - Next cycle out_valid=0, y=0, eq=0, match_cnt=0, in_ready=0.
  - After rst is released, in_ready=1.
